// File: rtl/seq_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential LEGv8 ALU.
// The control unit imports the same opcode constants.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        EXEC1,
        ITER,
        DONE
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UDIV);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per step,
// over a 2N-bit accumulator. lo/hi present the accumulator after the current step.
module seq_alu_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         step,
    output logic         finished,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc, acc_nxt;
    logic [N-1:0]   dv;
    logic           mode_q;
    logic [N-1:0]   addend;
    logic [N:0]     sum, trial;

    // mode 0: acc = {partial, multiplier}, dv = multiplicand
    // mode 1: acc = {remainder, dividend/quotient}, dv = divisor
    always_comb begin
        addend  = acc[0] ? dv : '0;
        sum     = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
        trial   = acc[2*N-1:N-1] - {1'b0, dv};
        acc_nxt = {acc[2*N-2:0], 1'b0};
        if (!mode_q) begin
            acc_nxt = {sum, acc[N-1:1]};
        end else if ((dv != '0) && !trial[N]) begin
            // A zero divisor never subtracts, leaving quotient 0 and remainder A.
            acc_nxt = {trial[N-1:0], acc[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(N - 1);
        end else if (step && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            mode_q <= mode;
            dv     <= mode ? b : a;
            acc    <= {{N{1'b0}}, (mode ? a : b)};
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

    assign finished = (cnt == '0);
    assign lo       = acc_nxt[N-1:0];
    assign hi       = acc_nxt[2*N-1:N];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle LEGv8 ALU: single-cycle logic/arith ops plus iterative MUL/UDIV,
// NZCV flags, start/ready/done handshake; results held until the next completion.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   OP,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] ALUOutput,
    output logic [N-1:0] ALUHigh,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         illegal
);
    state_t state, state_nxt;

    logic         accept, upd;
    logic [3:0]   op_p0;
    logic [N-1:0] a_p0, b_p0;
    logic         iter_finished;
    logic [N-1:0] iter_lo, iter_hi;
    logic [N:0]   add_w, sub_w;
    logic [N-1:0] res_lo, res_hi;
    logic         res_c, res_v, res_ill;

    function automatic logic add_ovf(input logic signed [N-1:0] x, y, s);
        return ((x < 0) == (y < 0)) && ((s < 0) != (x < 0));
    endfunction

    function automatic logic sub_ovf(input logic signed [N-1:0] x, y, s);
        return ((x < 0) != (y < 0)) && ((s < 0) != (x < 0));
    endfunction

    assign ready  = (state == IDLE) || (state == DONE);
    assign done   = (state == DONE);
    assign accept = start && ready;
    assign upd    = (state == EXEC1) || ((state == ITER) && iter_finished);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = is_iter_op(OP) ? ITER : EXEC1;
                else        state_nxt = IDLE;
            end
            EXEC1:   state_nxt = DONE;
            ITER:    if (iter_finished) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: operands and opcode captured at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= OP;
            a_p0  <= input1;
            b_p0  <= input2;
        end
    end

    seq_alu_iter #(.N(N)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .mode     (OP == OP_UDIV),
        .a        (input1),
        .b        (input2),
        .step     (state == ITER),
        .finished (iter_finished),
        .lo       (iter_lo),
        .hi       (iter_hi)
    );

    always_comb begin
        add_w   = {1'b0, a_p0} + {1'b0, b_p0};
        sub_w   = {1'b0, a_p0} + {1'b0, ~b_p0} + {{N{1'b0}}, 1'b1};
        res_lo  = '0;
        res_hi  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        if (state == ITER) begin
            res_lo = iter_lo;
            res_hi = iter_hi;
        end else begin
            case (op_p0)
                OP_AND:   res_lo = a_p0 & b_p0;
                OP_OR:    res_lo = a_p0 | b_p0;
                OP_ADD: begin
                    res_lo = add_w[N-1:0];
                    res_c  = add_w[N];
                    res_v  = add_ovf(a_p0, b_p0, add_w[N-1:0]);
                end
                OP_SUB: begin
                    res_lo = sub_w[N-1:0];
                    res_c  = sub_w[N];
                    res_v  = sub_ovf(a_p0, b_p0, sub_w[N-1:0]);
                end
                OP_PASSB: res_lo = b_p0;
                OP_NOR:   res_lo = ~(a_p0 | b_p0);
                default:  res_ill = 1'b1;
            endcase
        end
    end

    // Stage p1: result/flag registers, loaded only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUOutput <= '0;
            ALUHigh   <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (upd) begin
            ALUOutput <= res_lo;
            ALUHigh   <= res_hi;
            zero      <= !res_ill && (res_lo == '0);
            negative  <= res_lo[N-1];
            carry     <= res_c;
            overflow  <= res_v;
            illegal   <= res_ill;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a 64-bit and an 8-bit instance driven by directed
// and random operations, compared against an arithmetic reference model.
module tb_seq_alu;

    localparam logic [3:0] K_AND   = 4'h0;
    localparam logic [3:0] K_OR    = 4'h1;
    localparam logic [3:0] K_ADD   = 4'h2;
    localparam logic [3:0] K_SUB   = 4'h6;
    localparam logic [3:0] K_PASSB = 4'h7;
    localparam logic [3:0] K_NOR   = 4'hC;
    localparam logic [3:0] K_MUL   = 4'h8;
    localparam logic [3:0] K_UDIV  = 4'h9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s64, s8;
    logic [3:0]  op64, op8;
    logic [63:0] a64, b64;
    logic [7:0]  a8, b8;
    logic        rdy64, dn64, z64, n64, c64, v64, il64;
    logic        rdy8, dn8, z8, n8, c8, v8, il8;
    logic [63:0] y64, h64;
    logic [7:0]  y8, h8;

    int n_assert = 0;
    int n_fail   = 0;

    seq_alu #(.N(64)) dut64 (
        .clk(clk), .rst(rst), .start(s64), .OP(op64), .input1(a64), .input2(b64),
        .ready(rdy64), .done(dn64), .ALUOutput(y64), .ALUHigh(h64),
        .zero(z64), .negative(n64), .carry(c64), .overflow(v64), .illegal(il64)
    );

    seq_alu #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .OP(op8), .input1(a8), .input2(b8),
        .ready(rdy8), .done(dn8), .ALUOutput(y8), .ALUHigh(h8),
        .zero(z8), .negative(n8), .carry(c8), .overflow(v8), .illegal(il8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit big, output logic [63:0] lo, output logic [63:0] hi,
                          output logic [63:0] fl, output logic dn, output logic rd);
        if (big) begin
            lo = y64; hi = h64; fl = {59'b0, il64, z64, n64, c64, v64}; dn = dn64; rd = rdy64;
        end else begin
            lo = {56'b0, y8}; hi = {56'b0, h8}; fl = {59'b0, il8, z8, n8, c8, v8};
            dn = dn8; rd = rdy8;
        end
    endtask

    task automatic drive(input bit big, input logic st, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (big) begin
            s64 = st; op64 = op; a64 = a; b64 = b;
        end else begin
            s8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    // Reference: fl = {illegal, zero, negative, carry, overflow}
    function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] lo,
                                  output logic [63:0] hi, output logic [63:0] fl);
        logic [63:0]         mask;
        logic [127:0]        p;
        logic signed [127:0] sa, sb, r, mx, mn;
        logic                il, c, v;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        sa = $signed({64'b0, a} << (128 - w)) >>> (128 - w);
        sb = $signed({64'b0, b} << (128 - w)) >>> (128 - w);
        mx = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn = -mx - 128'sd1;
        il = 1'b0; c = 1'b0; v = 1'b0; lo = '0; hi = '0; p = '0; r = '0;
        case (op)
            K_AND:   lo = a & b;
            K_OR:    lo = a | b;
            K_ADD: begin
                p = {64'b0, a} + {64'b0, b};
                lo = p[63:0] & mask;
                c = (p > {64'b0, mask});
                r = sa + sb;
                v = (r > mx) || (r < mn);
            end
            K_SUB: begin
                lo = (a - b) & mask;
                c = (a >= b);
                r = sa - sb;
                v = (r > mx) || (r < mn);
            end
            K_PASSB: lo = b;
            K_NOR:   lo = ~(a | b) & mask;
            K_MUL: begin
                p = {64'b0, a} * {64'b0, b};
                lo = p[63:0] & mask;
                hi = 64'(p >> w) & mask;
            end
            K_UDIV: begin
                if (b == 64'd0) begin
                    lo = 64'd0; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: il = 1'b1;
        endcase
        fl = {59'b0, il, (!il && (lo == 64'd0)), lo[w-1], c, v};
    endfunction

    task automatic do_op(input bit big, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input string tag);
        int w, lat, exp_lat;
        logic [63:0] mask, am, bm, elo, ehi, efl, lo, hi, fl;
        logic dn, rd;
        w = big ? 64 : 8;
        mask = big ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
        am = a & mask;
        bm = b & mask;
        model(w, op, am, bm, elo, ehi, efl);
        exp_lat = ((op == K_MUL) || (op == K_UDIV)) ? w : 1;
        @(negedge clk);
        sample(big, lo, hi, fl, dn, rd);
        check({tag, "_ready"}, 64'(rd), 64'd1);
        drive(big, 1'b1, op, am, bm);
        @(posedge clk);
        #1;
        drive(big, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        lat = 0;
        dn = 1'b0;
        while (!dn && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            sample(big, lo, hi, fl, dn, rd);
            if (!dn) begin
                check({tag, "_busy"}, 64'(rd), 64'd0);
                drive(big, 1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        drive(big, 1'b0, op, am, bm);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out"}, lo, elo);
        check({tag, "_high"}, hi, ehi);
        check({tag, "_flags"}, fl, efl);
        @(posedge clk);
        #1;
        sample(big, lo, hi, fl, dn, rd);
        check({tag, "_pulse"}, 64'(dn), 64'd0);
        check({tag, "_hold"}, lo, elo);
    endtask

    initial begin
        logic [63:0] lo, hi, fl, elo, ehi, efl, ra, rb;
        logic        dn, rd;
        logic [3:0]  rop;
        bit          big;
        int          seen;
        logic [3:0]  ops [8] = '{K_AND, K_OR, K_ADD, K_SUB, K_PASSB, K_NOR, K_MUL, K_UDIV};

        // Reset held 3 cycles with start high
        rst = 1'b1;
        drive(1'b1, 1'b1, K_ADD, 64'd3, 64'd4);
        drive(1'b0, 1'b1, K_ADD, 64'd3, 64'd4);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            sample(k == 0, lo, hi, fl, dn, rd);
            check("rst_ready", 64'(rd), 64'd1);
            check("rst_done", 64'(dn), 64'd0);
            check("rst_out", lo, 64'd0);
            check("rst_high", hi, 64'd0);
            check("rst_flags", fl, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, K_ADD, 64'd0, 64'd0);
        drive(1'b0, 1'b0, K_ADD, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_done", 64'(dn64), 64'd0);
        check("post_rst_out", y64, 64'd0);

        // Directed cases
        do_op(1'b1, K_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_ovf");
        check("add_ovf_const", y64, 64'h8000_0000_0000_0000);
        check("add_ovf_nzcv", {59'b0, il64, z64, n64, c64, v64}, 64'b00101);
        do_op(1'b1, K_SUB, 64'd5, 64'd5, "sub_eq");
        check("sub_eq_nzcv", {59'b0, il64, z64, n64, c64, v64}, 64'b01010);
        do_op(1'b1, K_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mul64");
        check("mul64_lo_const", y64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mul64_hi_const", h64, 64'd1);
        do_op(1'b0, K_UDIV, 64'd200, 64'd7, "div8");
        check("div8_q_const", {56'b0, y8}, 64'd28);
        check("div8_r_const", {56'b0, h8}, 64'd4);
        do_op(1'b0, K_UDIV, 64'd200, 64'd0, "div8_by0");
        check("div8_by0_r_const", {56'b0, h8}, 64'd200);
        check("div8_by0_q_const", {56'b0, y8}, 64'd0);
        do_op(1'b1, 4'b0101, 64'd9, 64'd9, "illegal");
        check("illegal_const", {59'b0, il64, z64, n64, c64, v64}, 64'b10000);
        do_op(1'b0, K_SUB, 64'd3, 64'd4, "sub8_borrow");
        do_op(1'b0, K_ADD, 64'd127, 64'd129, "add8_carry");

        // Back-to-back AND then NOR with start held high
        @(negedge clk);
        drive(1'b1, 1'b1, K_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        @(posedge clk);
        #1;
        check("b2b_exec_ready", 64'(rdy64), 64'd0);
        @(posedge clk);
        #1;
        model(64, K_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, elo, ehi, efl);
        check("b2b_and_done", 64'(dn64), 64'd1);
        check("b2b_and_out", y64, elo);
        drive(1'b1, 1'b1, K_NOR, 64'h00FF_0000_0000_0001, 64'h0F00_0000_0000_0002);
        @(posedge clk);
        #1;
        check("b2b_gap_done", 64'(dn64), 64'd0);
        check("b2b_gap_hold", y64, elo);
        @(posedge clk);
        #1;
        model(64, K_NOR, 64'h00FF_0000_0000_0001, 64'h0F00_0000_0000_0002, elo, ehi, efl);
        check("b2b_nor_done", 64'(dn64), 64'd1);
        check("b2b_nor_out", y64, elo);
        check("b2b_nor_flags", {59'b0, il64, z64, n64, c64, v64}, efl);
        drive(1'b1, 1'b0, K_AND, 64'd0, 64'd0);

        // Random operations on both widths
        for (int i = 0; i < 40; i++) begin
            big = (i % 2) == 0;
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            do_op(big, rop, ra, rb, "rand");
        end

        // Reset mid-MUL at cycle k+10
        do_op(1'b1, K_ADD, 64'd3, 64'd4, "pre_rst");
        @(negedge clk);
        drive(1'b1, 1'b1, K_MUL, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, K_MUL, 64'd0, 64'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", 64'(rdy64), 64'd1);
        check("midrst_done", 64'(dn64), 64'd0);
        check("midrst_out", y64, 64'd0);
        check("midrst_flags", {59'b0, il64, z64, n64, c64, v64}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (dn64) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        do_op(1'b1, K_MUL, {$urandom, $urandom}, {$urandom, $urandom}, "mul_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
